i2s_capture_ctrl: RTL and testbench

Sequencer that turns the I2S receiver and its sample FIFO into a self-running capture engine. It enables the receiver, pops samples from the FIFO and writes each one over a simple request/acknowledge port into a word-addressed buffer memory, as single-shot or circular (ring) capture. It raises half-buffer and full-buffer events, detects FIFO overrun, and drains the FIFO on a stop request. It sits between the EF_I2S instance (fifo_* ports, en) and a shared SRAM or bus write master.

---
 rtl/i2s_capture_ctrl_if.sv | 24 ++
 rtl/i2s_capture_ctrl.sv | 177 +++++++++++++++++
 tb/tb_i2s_capture_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_capture_ctrl_if.sv
// Sample FIFO and buffer-memory write port of the I2S capture controller.
// master: capture controller side; slave: FIFO / memory side.
interface i2s_capture_ctrl_if #(
   parameter int unsigned AW = 10
);
   logic          fifo_empty;
   logic          fifo_full;
   logic [31:0]   fifo_rdata;
   logic          fifo_rd;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_ack;

   modport master (
      input  fifo_empty, fifo_full, fifo_rdata, mem_ack,
      output fifo_rd, mem_req, mem_addr, mem_wdata
   );

   modport slave (
      output fifo_empty, fifo_full, fifo_rdata, mem_ack,
      input  fifo_rd, mem_req, mem_addr, mem_wdata
   );
endinterface

// File: rtl/i2s_capture_ctrl.sv
// Capture sequencer: enables the I2S receiver, pops its FIFO and writes each
// sample into a word-addressed buffer, single-shot or circular, with half/full
// buffer events, sticky FIFO overrun and drain-on-stop.
module i2s_capture_ctrl #(
   parameter int unsigned AW = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_i,
   input  logic                   stop_i,
   input  logic                   circular_i,
   input  logic [AW-1:0]          buf_last_i,
   output logic                   i2s_en_o,
   i2s_capture_ctrl_if.master     bus_io,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   half_evt_o,
   output logic                   full_evt_o,
   output logic                   overrun_o
);

   typedef enum logic [1:0] {StIdle, StFetch, StWrite} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] last_q, last_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic          circ_q, circ_d;
   logic          stopping_q, stopping_d;
   logic          i2s_en_q, i2s_en_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          mem_req_q;
   logic          busy_q;
   logic          done_q, done_d;
   logic          half_q, half_d;
   logic          full_q, full_d;
   logic          overrun_q, overrun_d;

   logic accept;
   logic pop;
   logic acked;
   logic at_last;
   logic at_half;

   // start is only honoured from IDLE and loses against a simultaneous stop
   assign accept  = (state_q == StIdle) && start_i && !stop_i;
   assign pop     = (state_q == StFetch) && !bus_io.fifo_empty;
   assign acked   = (state_q == StWrite) && bus_io.mem_ack;
   assign at_last = (ptr_q == last_q);
   assign at_half = (ptr_q == (last_q >> 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) state_d = StFetch;
         end
         StFetch: begin
            // Draining continues as long as the FIFO has data, even when stopping
            if (!bus_io.fifo_empty) begin
               state_d = StWrite;
            end else if (stopping_q) begin
               state_d = StIdle;
            end
         end
         StWrite: begin
            if (bus_io.mem_ack) begin
               state_d = (at_last && !circ_q) ? StIdle : StFetch;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath and event next-state values
   always_comb begin
      last_d     = last_q;
      circ_d     = circ_q;
      ptr_d      = ptr_q;
      stopping_d = stopping_q;
      i2s_en_d   = i2s_en_q;
      wdata_d    = wdata_q;
      done_d     = 1'b0;
      half_d     = 1'b0;
      full_d     = 1'b0;

      if (accept) begin
         last_d     = buf_last_i;
         circ_d     = circular_i;
         ptr_d      = '0;
         stopping_d = 1'b0;
         i2s_en_d   = 1'b1;
      end

      if (pop) wdata_d = bus_io.fifo_rdata;

      if (acked) begin
         half_d = at_half;
         full_d = at_last;
         if (at_last) begin
            if (circ_q) begin
               ptr_d = '0;
            end else begin
               // Single-shot end: leave any remaining FIFO words unread
               i2s_en_d = 1'b0;
               done_d   = 1'b1;
            end
         end else begin
            ptr_d = ptr_q + 1'b1;
         end
      end

      if ((state_q == StFetch) && bus_io.fifo_empty && stopping_q) done_d = 1'b1;

      if (stop_i && (state_q != StIdle)) begin
         stopping_d = 1'b1;
         i2s_en_d   = 1'b0;
      end

      overrun_d = accept ? 1'b0 : (overrun_q | (bus_io.fifo_full & i2s_en_q));
   end

   // Datapath and registered-output flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q     <= '0;
         circ_q     <= 1'b0;
         ptr_q      <= '0;
         stopping_q <= 1'b0;
         i2s_en_q   <= 1'b0;
         wdata_q    <= '0;
         mem_req_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         half_q     <= 1'b0;
         full_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         last_q     <= last_d;
         circ_q     <= circ_d;
         ptr_q      <= ptr_d;
         stopping_q <= stopping_d;
         i2s_en_q   <= i2s_en_d;
         wdata_q    <= wdata_d;
         mem_req_q  <= (state_d == StWrite);
         busy_q     <= (state_d != StIdle);
         done_q     <= done_d;
         half_q     <= half_d;
         full_q     <= full_d;
         overrun_q  <= overrun_d;
      end
   end

   // Outputs: all registered except the FIFO pop strobe
   always_comb begin
      bus_io.fifo_rd   = pop;
      bus_io.mem_req   = mem_req_q;
      bus_io.mem_addr  = ptr_q;
      bus_io.mem_wdata = wdata_q;
      i2s_en_o         = i2s_en_q;
      busy_o           = busy_q;
      done_o           = done_q;
      half_evt_o       = half_q;
      full_evt_o       = full_q;
      overrun_o        = overrun_q;
   end

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Bench for i2s_capture_ctrl: FIFO and memory models, write scoreboard,
// table of capture runs plus hand-written stop / overrun / reset sequences.
module tb_i2s_capture_ctrl;
   localparam int unsigned AW = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, stop, circular;
   logic [AW-1:0] buf_last;
   logic          i2s_en, busy, done, half_evt, full_evt, overrun;

   i2s_capture_ctrl_if #(.AW(AW)) bus ();

   i2s_capture_ctrl #(.AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start),
      .stop_i     (stop),
      .circular_i (circular),
      .buf_last_i (buf_last),
      .i2s_en_o   (i2s_en),
      .bus_io     (bus),
      .busy_o     (busy),
      .done_o     (done),
      .half_evt_o (half_evt),
      .full_evt_o (full_evt),
      .overrun_o  (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   typedef struct {
      bit circ;
      int last;
      int n;
      int max_wait;
      int exp_half;
      int exp_full;
      int exp_left;
   } vec_t;

   wr_t         exp_q[$];
   logic [31:0] fifo_q[$];
   vec_t        vecs[7];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cnt, first_acc, last_acc;
   int half_cnt = 0, full_cnt = 0, done_cnt = 0;
   int cur_last = 0;
   int max_wait = 0;
   bit wait_fixed = 0;
   bit pop_pend = 0, req_seen = 0;
   int wait_cnt = 0;
   bit exp_half_nxt = 0, exp_full_nxt = 0;
   bit hold_valid = 0;
   logic [31:0] hold_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // FIFO/memory model and scoreboard, one iteration per clock
   task automatic responder();
      wr_t         e;
      logic [31:0] tmp;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (pop_pend && fifo_q.size() > 0) tmp = fifo_q.pop_front();
         pop_pend = 0;
         bus.fifo_empty = (fifo_q.size() == 0);
         bus.fifo_rdata = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
         if (!bus.mem_req) begin
            req_seen    = 0;
            bus.mem_ack = 1'b0;
         end else begin
            if (!req_seen) begin
               wait_cnt = wait_fixed ? max_wait : int'($urandom_range(max_wait, 0));
               req_seen = 1;
            end
            if (wait_cnt == 0) begin
               bus.mem_ack = 1'b1;
            end else begin
               bus.mem_ack = 1'b0;
               wait_cnt--;
            end
         end
         @(negedge clk);
         chk("half_evt_timing", half_evt, exp_half_nxt);
         chk("full_evt_timing", full_evt, exp_full_nxt);
         if (half_evt) half_cnt++;
         if (full_evt) full_cnt++;
         if (done) done_cnt++;
         exp_half_nxt = 0;
         exp_full_nxt = 0;
         if (hold_valid && bus.mem_req) chk("wdata_stable", bus.mem_wdata, hold_data);
         hold_valid = bus.mem_req && !bus.mem_ack;
         hold_data  = bus.mem_wdata;
         if (bus.fifo_rd) pop_pend = 1;
         if (bus.mem_req && bus.mem_ack) begin
            acc_cnt++;
            if (acc_cnt == 1) first_acc = cyc;
            last_acc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                        bus.mem_addr, bus.mem_wdata);
            end else begin
               e = exp_q.pop_front();
               chk("write_addr", bus.mem_addr, e.addr);
               chk("write_data", bus.mem_wdata, e.data);
            end
            exp_half_nxt = (int'(bus.mem_addr) == (cur_last >> 1));
            exp_full_nxt = (int'(bus.mem_addr) == cur_last);
         end
      end
   endtask

   task automatic push_word(input logic [31:0] data, input int addr, input bit expect_wr);
      wr_t e;
      fifo_q.push_back(data);
      if (expect_wr) begin
         e.addr = addr[AW-1:0];
         e.data = data;
         exp_q.push_back(e);
      end
   endtask

   task automatic pulse_start(input bit circ, input int last);
      @(negedge clk);
      circular = circ;
      buf_last = last[AW-1:0];
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      int t = 0;
      while (done_cnt == d0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("done_seen", done_cnt != d0, 1);
   endtask

   task automatic wait_drained();
      int t = 0;
      while (!(exp_q.size() == 0 && bus.mem_req == 1'b0) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("drain_in_time", exp_q.size(), 0);
   endtask

   task automatic run_vec(input vec_t v, input int k);
      int nexp = 0;
      int d0, h0, f0, t;
      cur_last   = v.last;
      max_wait   = v.max_wait;
      wait_fixed = 0;
      acc_cnt    = 0;
      for (int i = 0; i < v.n; i++) begin
         push_word((k << 24) | (32'h11 * (i + 1)), i % (v.last + 1), v.circ || i <= v.last);
         if (v.circ || i <= v.last) nexp++;
      end
      d0 = done_cnt;
      h0 = half_cnt;
      f0 = full_cnt;
      pulse_start(v.circ, v.last);
      chk("start_busy", busy, 1);
      chk("start_i2s_en", i2s_en, 1);
      chk("start_clears_overrun", overrun, 0);
      t = 0;
      while (done_cnt == d0 && !(exp_q.size() == 0 && bus.mem_req == 1'b0) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      if (done_cnt == d0) pulse_stop();
      wait_done(d0);
      repeat (3) @(negedge clk);
      chk("run_done_count", done_cnt - d0, 1);
      chk("run_half_count", half_cnt - h0, v.exp_half);
      chk("run_full_count", full_cnt - f0, v.exp_full);
      chk("run_writes_left", exp_q.size(), 0);
      chk("run_fifo_left", fifo_q.size(), v.exp_left);
      chk("run_end_i2s_en", i2s_en, 0);
      chk("run_end_busy", busy, 0);
      if (v.max_wait == 0 && nexp > 1) chk("throughput", last_acc - first_acc, 2 * (nexp - 1));
      fifo_q.delete();
      exp_q.delete();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int d0, h0, f0, t;
      //          circ last  n  wait half full left
      vecs[0] = '{1'b0, 7,  8, 0, 1, 1, 0};
      vecs[1] = '{1'b1, 3, 10, 3, 3, 2, 0};
      vecs[2] = '{1'b0, 0,  3, 1, 1, 1, 2};
      vecs[3] = '{1'b1, 0,  3, 0, 3, 3, 0};
      vecs[4] = '{1'b0, 5,  3, 2, 1, 0, 0};
      vecs[5] = '{1'b0, 7, 10, 0, 1, 1, 2};
      vecs[6] = '{1'b1, 4,  7, 2, 1, 1, 0};

      start = 0; stop = 0; circular = 0; buf_last = '0;
      bus.fifo_empty = 1'b1; bus.fifo_full = 1'b0; bus.fifo_rdata = '0; bus.mem_ack = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_i2s_en", i2s_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_fifo_rd", bus.fifo_rd, 0);
      chk("rst_events", {done, half_evt, full_evt, overrun}, 0);
      fork
         responder();
      join_none
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

      // start and stop together in IDLE are both ignored
      @(negedge clk);
      circular = 0; buf_last = 3; start = 1; stop = 1;
      @(negedge clk);
      start = 0; stop = 0;
      chk("start_stop_busy", busy, 0);
      chk("start_stop_i2s_en", i2s_en, 0);

      // start while busy must not disturb the pointer
      cur_last = 7; max_wait = 1; wait_fixed = 0;
      push_word(32'hA0A0_0001, 0, 1);
      push_word(32'hA0A0_0002, 1, 1);
      pulse_start(1, 7);
      wait_drained();
      pulse_start(0, 0);
      chk("busy_start_ignored", busy, 1);
      push_word(32'hA0A0_0003, 2, 1);
      wait_drained();
      d0 = done_cnt;
      pulse_stop();
      wait_done(d0);
      repeat (2) @(negedge clk);

      // stop during WRITE with three words still queued
      cur_last = 15; max_wait = 3; wait_fixed = 1;
      for (int i = 0; i < 5; i++) push_word(32'hB000_0000 + i, i, 1);
      d0 = done_cnt; h0 = half_cnt; f0 = full_cnt;
      pulse_start(0, 15);
      t = 0;
      while (!(fifo_q.size() == 3 && bus.mem_req && !bus.mem_ack) && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("stop_setup_reached", t < 200, 1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("stop_i2s_en_fall", i2s_en, 0);
      chk("stop_still_busy", busy, 1);
      wait_done(d0);
      repeat (3) @(negedge clk);
      chk("stop_all_written", exp_q.size(), 0);
      chk("stop_fifo_drained", fifo_q.size(), 0);
      chk("stop_done_count", done_cnt - d0, 1);
      chk("stop_no_events", (half_cnt - h0) + (full_cnt - f0), 0);
      wait_fixed = 0;

      // overrun: ignored in IDLE, sticky while capturing, cleared by next start
      @(negedge clk) bus.fifo_full = 1'b1;
      @(negedge clk) bus.fifo_full = 1'b0;
      chk("overrun_idle", overrun, 0);
      cur_last = 7; max_wait = 0;
      pulse_start(1, 7);
      @(negedge clk) bus.fifo_full = 1'b1;
      @(negedge clk) bus.fifo_full = 1'b0;
      chk("overrun_set", overrun, 1);
      push_word(32'hC000_0001, 0, 1);
      push_word(32'hC000_0002, 1, 1);
      wait_drained();
      d0 = done_cnt;
      pulse_stop();
      wait_done(d0);
      repeat (2) @(negedge clk);
      chk("overrun_sticky", overrun, 1);

      // asynchronous reset in the middle of a write
      cur_last = 7; max_wait = 5; wait_fixed = 1; acc_cnt = 0;
      push_word(32'hD000_0001, 0, 1);
      push_word(32'hD000_0002, 1, 1);
      pulse_start(0, 7);
      t = 0;
      while (!(acc_cnt >= 1 && bus.mem_req) && t < 200) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_mem_req", bus.mem_req, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_i2s_en", i2s_en, 0);
      chk("midrst_mem_addr", bus.mem_addr, 0);
      chk("midrst_mem_wdata", bus.mem_wdata, 0);
      chk("midrst_overrun", overrun, 0);
      exp_q.delete();
      fifo_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run_vec(vecs[0], 9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
